// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: opcode encoding and default widths.
package mem_access_stage_pkg;

    localparam int OP_W = 3;
    localparam int DATA_W_DEFAULT = 8;
    localparam logic [7:0] SP_INIT_DEFAULT = 8'hFF;

    // Encodings 6 and 7 are unused and decode as NOP.
    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_PASS  = 3'd1,
        OP_LOAD  = 3'd2,
        OP_STORE = 3'd3,
        OP_PUSH  = 3'd4,
        OP_POP   = 3'd5
    } op_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM input, data-memory and MEM/WB output signals of the MEM stage.
// slave = the stage itself, master = its environment (EX, memory, write-back).
interface mem_access_stage_if #(
    parameter int Width = mem_access_stage_pkg::DATA_W_DEFAULT
);
    import mem_access_stage_pkg::*;

    logic             In_Valid;
    logic             In_Ready;
    logic [OP_W-1:0]  In_Op;
    logic [Width-1:0] In_Addr;
    logic [Width-1:0] In_Data;
    logic [1:0]       In_Rd;
    logic             In_Reg_Write;

    logic             Mem_Write_EN;
    logic             Mem_Read_EN;
    logic [Width-1:0] Mem_Address;
    logic [Width-1:0] Mem_Write_D;
    logic [Width-1:0] Mem_Read_D;

    logic             Out_Valid;
    logic             Out_Ready;
    logic [Width-1:0] Out_Data;
    logic [1:0]       Out_Rd;
    logic             Out_Reg_Write;

    logic [Width-1:0] SP;
    logic             Stack_Fault;

    modport slave (
        input  In_Valid, In_Op, In_Addr, In_Data, In_Rd, In_Reg_Write,
        input  Mem_Read_D, Out_Ready,
        output In_Ready, Mem_Write_EN, Mem_Read_EN, Mem_Address, Mem_Write_D,
        output Out_Valid, Out_Data, Out_Rd, Out_Reg_Write, SP, Stack_Fault
    );

    modport master (
        output In_Valid, In_Op, In_Addr, In_Data, In_Rd, In_Reg_Write,
        output Mem_Read_D, Out_Ready,
        input  In_Ready, Mem_Write_EN, Mem_Read_EN, Mem_Address, Mem_Write_D,
        input  Out_Valid, Out_Data, Out_Rd, Out_Reg_Write, SP, Stack_Fault
    );

endinterface

// File: rtl/mem_access_stage_mem_wb.sv
// One-entry MEM/WB register (data, rd, reg-write); latency 1, full throughput.
// Ready while empty or draining this cycle; held low during reset so nothing is accepted.
module mem_wb_reg #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_vld,
    output logic             enq_rdy,
    input  logic [Width-1:0] enq_dat,
    input  logic [1:0]       enq_rd,
    input  logic             enq_wr,
    output logic             deq_vld,
    input  logic             deq_rdy,
    output logic [Width-1:0] deq_dat,
    output logic [1:0]       deq_rd,
    output logic             deq_wr
);

    assign enq_rdy = !rst && (!deq_vld || deq_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deq_vld <= 1'b0;
            deq_dat <= '0;
            deq_rd  <= '0;
            deq_wr  <= 1'b0;
        end else if (enq_vld && enq_rdy) begin
            deq_vld <= 1'b1;
            deq_dat <= enq_dat;
            deq_rd  <= enq_rd;
            deq_wr  <= enq_wr;
        end else if (deq_rdy) begin
            // Fields are left as-is once drained; only valid drops.
            deq_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives data memory on accept, registers result to MEM/WB (latency 1); stalls
// without re-issuing memory side effects. STACK_OPS_EN enables PUSH/POP and the stack pointer.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int               Width   = DATA_W_DEFAULT,
    parameter logic [Width-1:0] SP_Init = Width'(SP_INIT_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RST,
    mem_access_stage_if.slave bus
);

    logic             stage_rdy;
    logic             accept;
    logic             wr_en;
    logic             rd_en;
    logic [Width-1:0] addr;
    logic [Width-1:0] wdata;
    logic [Width-1:0] result;
    logic             reg_wr;

`ifdef STACK_OPS_EN
    logic [Width-1:0] sp_q;
    logic [Width-1:0] sp_d;
    logic             fault_q;
    logic             fault_d;
`endif

    assign accept = bus.In_Valid && stage_rdy;

    // Everything is gated by accept so an idle or stalled stage never touches memory.
    always_comb begin
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        addr   = '0;
        wdata  = '0;
        result = '0;
        reg_wr = 1'b0;
`ifdef STACK_OPS_EN
        sp_d    = sp_q;
        fault_d = fault_q;
`endif
        if (accept) begin
            case (bus.In_Op)
                OP_PASS: begin
                    result = bus.In_Data;
                    reg_wr = bus.In_Reg_Write;
                end
                OP_LOAD: begin
                    rd_en  = 1'b1;
                    addr   = bus.In_Addr;
                    result = bus.Mem_Read_D;
                    reg_wr = bus.In_Reg_Write;
                end
                OP_STORE: begin
                    wr_en = 1'b1;
                    addr  = bus.In_Addr;
                    wdata = bus.In_Data;
                end
`ifdef STACK_OPS_EN
                // Stack grows downward; SP points at the next free slot.
                OP_PUSH: begin
                    wr_en = 1'b1;
                    addr  = sp_q;
                    wdata = bus.In_Data;
                    sp_d  = sp_q - 1'b1;
                    if (sp_q == '0) fault_d = 1'b1;
                end
                OP_POP: begin
                    rd_en  = 1'b1;
                    addr   = sp_q + 1'b1;
                    result = bus.Mem_Read_D;
                    reg_wr = bus.In_Reg_Write;
                    sp_d   = sp_q + 1'b1;
                    if (sp_q == SP_Init) fault_d = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef STACK_OPS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sp_q    <= SP_Init;
            fault_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end

    assign bus.SP          = sp_q;
    assign bus.Stack_Fault = fault_q;
`else
    assign bus.SP          = SP_Init;
    assign bus.Stack_Fault = 1'b0;
`endif

    assign bus.In_Ready     = stage_rdy;
    assign bus.Mem_Write_EN = wr_en;
    assign bus.Mem_Read_EN  = rd_en;
    assign bus.Mem_Address  = addr;
    assign bus.Mem_Write_D  = wdata;

    mem_wb_reg #(
        .Width (Width)
    ) u_mem_wb (
        .clk     (CLK),
        .rst     (RST),
        .enq_vld (bus.In_Valid),
        .enq_rdy (stage_rdy),
        .enq_dat (result),
        .enq_rd  (bus.In_Rd),
        .enq_wr  (reg_wr),
        .deq_vld (bus.Out_Valid),
        .deq_rdy (bus.Out_Ready),
        .deq_dat (bus.Out_Data),
        .deq_rd  (bus.Out_Rd),
        .deq_wr  (bus.Out_Reg_Write)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a behavioural data memory; stack cases follow STACK_OPS_EN.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   n_chk = 0;
    int   n_err = 0;
    int   wr_count = 0;
    int   w0;
    logic [7:0] mem [256];

    mem_access_stage_if #(.Width(8)) bus ();

    mem_access_stage #(.Width(8), .SP_Init(8'hFF)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.Mem_Read_D = mem[bus.Mem_Address];

    always @(posedge CLK) begin
        if (bus.Mem_Write_EN === 1'b1) begin
            mem[bus.Mem_Address] <= bus.Mem_Write_D;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] d, input logic [1:0] rd, input logic rw);
        bus.In_Valid     = v;
        bus.In_Op        = op;
        bus.In_Addr      = a;
        bus.In_Data      = d;
        bus.In_Rd        = rd;
        bus.In_Reg_Write = rw;
    endtask

    task automatic idle();
        drive(1'b0, OP_NOP, 8'h00, 8'h00, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        step();
        RST = 1'b1;
        idle();
        step();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        idle();
        bus.Out_Ready = 1'b1;
        @(negedge CLK);
        chk("rdy_in_rst", bus.In_Ready, 0);
        chk("vld_in_rst", bus.Out_Valid, 0);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_vld", bus.Out_Valid, 0);
        chk("rst_dat", bus.Out_Data, 0);
        chk("rst_rd", bus.Out_Rd, 0);
        chk("rst_rw", bus.Out_Reg_Write, 0);
        chk("rst_sp", bus.SP, 8'hFF);
        chk("rst_fault", bus.Stack_Fault, 0);
        chk("rst_rdy", bus.In_Ready, 1);
        chk("rst_we", bus.Mem_Write_EN, 0);
        chk("rst_addr", bus.Mem_Address, 0);

        // STORE then LOAD of the same address
        step();
        drive(1'b1, OP_STORE, 8'h10, 8'hA5, 2'd1, 1'b1);
        @(negedge CLK);
        chk("st_we", bus.Mem_Write_EN, 1);
        chk("st_re", bus.Mem_Read_EN, 0);
        chk("st_addr", bus.Mem_Address, 8'h10);
        chk("st_wd", bus.Mem_Write_D, 8'hA5);
        step();
        drive(1'b1, OP_LOAD, 8'h10, 8'h00, 2'd2, 1'b1);
        @(negedge CLK);
        chk("st_out_vld", bus.Out_Valid, 1);
        chk("st_out_rw", bus.Out_Reg_Write, 0);
        chk("ld_re", bus.Mem_Read_EN, 1);
        chk("ld_we", bus.Mem_Write_EN, 0);
        chk("ld_addr", bus.Mem_Address, 8'h10);
        step();
        idle();
        @(negedge CLK);
        chk("ld_vld", bus.Out_Valid, 1);
        chk("ld_dat", bus.Out_Data, 8'hA5);
        chk("ld_rd", bus.Out_Rd, 2);
        chk("ld_rw", bus.Out_Reg_Write, 1);
        chk("idle_re", bus.Mem_Read_EN, 0);
        chk("idle_addr", bus.Mem_Address, 0);
        step();
        @(negedge CLK);
        chk("drain_vld", bus.Out_Valid, 0);

        // Write-back stall with a STORE waiting at the input
        step();
        drive(1'b1, OP_PASS, 8'h00, 8'h33, 2'd1, 1'b1);
        step();
        bus.Out_Ready = 1'b0;
        drive(1'b1, OP_STORE, 8'h20, 8'h5A, 2'd0, 1'b0);
        w0 = wr_count;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_rdy", bus.In_Ready, 0);
            chk("stall_we", bus.Mem_Write_EN, 0);
            chk("stall_dat", bus.Out_Data, 8'h33);
            chk("stall_vld", bus.Out_Valid, 1);
            step();
        end
        bus.Out_Ready = 1'b1;
        @(negedge CLK);
        chk("rel_rdy", bus.In_Ready, 1);
        chk("rel_we", bus.Mem_Write_EN, 1);
        step();
        idle();
        @(negedge CLK);
        chk("rel_wr_cnt", wr_count - w0, 1);
        chk("rel_mem", mem[8'h20], 8'h5A);
        chk("rel_vld", bus.Out_Valid, 1);
        chk("rel_rw", bus.Out_Reg_Write, 0);

        // Back-to-back PASS stream
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, OP_PASS, 8'h00, 8'(8'h40 + i), 2'(i), 1'b1);
            @(negedge CLK);
            chk("pass_rdy", bus.In_Ready, 1);
            if (i > 0) begin
                chk("pass_dat", bus.Out_Data, 8'(8'h40 + i - 1));
                chk("pass_vld", bus.Out_Valid, 1);
            end
            step();
        end
        idle();
        @(negedge CLK);
        chk("pass_last", bus.Out_Data, 8'h45);
        chk("pass_last_rd", bus.Out_Rd, 1);

`ifdef STACK_OPS_EN
        do_reset();
        drive(1'b1, OP_PUSH, 8'h00, 8'h11, 2'd0, 1'b1);
        @(negedge CLK);
        chk("push1_we", bus.Mem_Write_EN, 1);
        chk("push1_addr", bus.Mem_Address, 8'hFF);
        chk("push1_wd", bus.Mem_Write_D, 8'h11);
        step();
        drive(1'b1, OP_PUSH, 8'h00, 8'h22, 2'd0, 1'b1);
        @(negedge CLK);
        chk("push2_addr", bus.Mem_Address, 8'hFE);
        chk("push2_sp", bus.SP, 8'hFE);
        chk("push1_rw", bus.Out_Reg_Write, 0);
        step();
        drive(1'b1, OP_POP, 8'h00, 8'h00, 2'd1, 1'b1);
        @(negedge CLK);
        chk("pop1_re", bus.Mem_Read_EN, 1);
        chk("pop1_addr", bus.Mem_Address, 8'hFE);
        step();
        drive(1'b1, OP_POP, 8'h00, 8'h00, 2'd3, 1'b1);
        @(negedge CLK);
        chk("pop1_dat", bus.Out_Data, 8'h22);
        chk("pop1_rd", bus.Out_Rd, 1);
        chk("pop1_rw", bus.Out_Reg_Write, 1);
        chk("pop2_addr", bus.Mem_Address, 8'hFF);
        step();
        idle();
        @(negedge CLK);
        chk("pop2_dat", bus.Out_Data, 8'h11);
        chk("pop2_sp", bus.SP, 8'hFF);
        chk("pop2_fault", bus.Stack_Fault, 0);

        do_reset();
        drive(1'b1, OP_POP, 8'h00, 8'h00, 2'd0, 1'b0);
        step();
        idle();
        @(negedge CLK);
        chk("uf_fault", bus.Stack_Fault, 1);
        chk("uf_sp", bus.SP, 8'h00);
        repeat (3) step();
        @(negedge CLK);
        chk("uf_sticky", bus.Stack_Fault, 1);
        do_reset();
        @(negedge CLK);
        chk("uf_clear", bus.Stack_Fault, 0);
`else
        do_reset();
        drive(1'b1, OP_PUSH, 8'h00, 8'h11, 2'd1, 1'b1);
        w0 = wr_count;
        @(negedge CLK);
        chk("nopush_we", bus.Mem_Write_EN, 0);
        step();
        idle();
        @(negedge CLK);
        chk("nopush_wr_cnt", wr_count - w0, 0);
        chk("nopush_vld", bus.Out_Valid, 1);
        chk("nopush_rw", bus.Out_Reg_Write, 0);
        chk("nopush_sp", bus.SP, 8'hFF);
        chk("nopush_fault", bus.Stack_Fault, 0);
`endif

        // Reset while a result is stalled and a STORE waits at the input
        step();
        bus.Out_Ready = 1'b0;
        drive(1'b1, OP_PASS, 8'h00, 8'h77, 2'd2, 1'b1);
        step();
        drive(1'b1, OP_STORE, 8'h30, 8'hC3, 2'd0, 1'b0);
        w0 = wr_count;
        @(negedge CLK);
        chk("ms_vld", bus.Out_Valid, 1);
        chk("ms_we", bus.Mem_Write_EN, 0);
        #2;
        RST = 1'b1;
        #1;
        chk("ms_rst_vld", bus.Out_Valid, 0);
        chk("ms_rst_we", bus.Mem_Write_EN, 0);
        chk("ms_rst_sp", bus.SP, 8'hFF);
        chk("ms_rst_rdy", bus.In_Ready, 0);
        step();
        step();
        chk("ms_wr_cnt", wr_count - w0, 0);
        RST = 1'b0;
        idle();
        bus.Out_Ready = 1'b1;
        @(negedge CLK);
        chk("ms_post_vld", bus.Out_Valid, 0);
        chk("ms_post_rdy", bus.In_Ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the 8-bit processor: takes one decoded memory operation per cycle from the EX/MEM boundary, drives the data memory's write/read/address ports, and registers the result into the MEM/WB pipeline register toward write-back. It also owns the hardware stack pointer for PUSH/POP. Back-pressure from write-back stalls the stage without repeating memory side effects.

## Interface
- Width, 8, data and address width
- SP_Init, 8'hFF, stack pointer reset value
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- In_Valid  in  1  EX presents an operation
- In_Ready  out  1  stage can accept this cycle
- In_Op  in  3  0 NOP, 1 PASS, 2 LOAD, 3 STORE, 4 PUSH, 5 POP, 6–7 treated as NOP
- In_Addr  in  Width  LOAD/STORE address
- In_Data  in  Width  STORE/PUSH data; PASS result
- In_Rd  in  2  destination register
- In_Reg_Write  in  1  op writes a register
- Mem_Write_EN  out  1  to memory write enable
- Mem_Read_EN  out  1  to memory read enable
- Mem_Address  out  Width  to memory address
- Mem_Write_D  out  Width  to memory write data
- Mem_Read_D  in  Width  combinational read data from memory
- Out_Valid  out  1  MEM/WB register holds a result
- Out_Ready  in  1  write-back consumes this cycle
- Out_Data  out  Width  result (load data or PASS data)
- Out_Rd  out  2  destination register
- Out_Reg_Write  out  1  write-back enable
- SP  out  Width  current stack pointer
- Stack_Fault  out  1  sticky overflow/underflow flag

## Operation
- accept = In_Valid & In_Ready; In_Ready = !Out_Valid | Out_Ready (one-entry register, full throughput).
- Memory ports are combinational from inputs and asserted only on accept; no access when stalled or idle. Idle: enables 0, Mem_Address/Mem_Write_D 0.
- LOAD: Mem_Read_EN=1, address In_Addr; Out_Data ← Mem_Read_D.
- STORE: Mem_Write_EN=1, address In_Addr, data In_Data; Out_Reg_Write forced 0.
- PUSH: write In_Data at SP; SP ← SP−1; Out_Reg_Write forced 0.
- POP: read at SP+1; SP ← SP+1; Out_Data ← Mem_Read_D.
- PASS: no memory access; Out_Data ← In_Data. NOP/illegal: accepted, Out_Valid set, Out_Reg_Write 0.
- Width arithmetic on SP wraps modulo 2^Width. PUSH with SP=0 (wraps to FF) or POP with SP=SP_Init sets Stack_Fault; operation still performed. Stack_Fault clears only on RST.
- Output register loads on accept; when Out_Valid & Out_Ready & !accept, Out_Valid ← 0. Stalled output holds all fields stable.

## Timing
- Reset: Out_Valid 0, Out_Data 0, Out_Rd 0, Out_Reg_Write 0, SP = SP_Init, Stack_Fault 0; In_Ready 1 once reset released.
- Memory side effect occurs in the accept cycle's clock edge; result visible on Out_* the cycle after accept (latency 1).
- Back-to-back PUSH/POP use the SP updated by the previous edge; no bubbles.
- Simultaneous drain and accept: register replaced, Out_Valid stays 1.
- RST mid-stall: pending result discarded, no memory write issued.

## Configuration
- STACK_OPS_EN defined: PUSH/POP, SP register, SP and Stack_Fault ports behave as above.
- Undefined: PUSH/POP decode as NOP, no SP register; SP port ties to SP_Init, Stack_Fault ties to 0.

## Structure
- Shared package: opcode constants (OP_NOP … OP_POP), opcode width, SP_Init default.
- One sub-module natural: mem_wb_reg (valid/ready one-entry pipeline register holding Data, Rd, Reg_Write).

## Test plan
- Reset, then STORE addr 8'h10 data 8'hA5, LOAD 8'h10 Rd 2 → Out_Data 8'hA5, Out_Rd 2, Out_Reg_Write 1 one cycle after LOAD accept.
- PUSH 8'h11, PUSH 8'h22, POP, POP → writes at FF,FE; pops return 8'h22 then 8'h11; SP back to FF, Stack_Fault 0.
- POP right after reset → Stack_Fault 1, SP 8'h00; stays 1 until RST.
- Out_Ready low 3 cycles with STORE pending at input → In_Ready 0, Mem_Write_EN 0 during stall, exactly one write on release.
- Continuous PASS stream with Out_Ready 1 → one result per cycle, data in order, no bubbles.
- RST asserted while Out_Valid 1 and stalled → Out_Valid 0 immediately, SP = FF; with STACK_OPS_EN undefined, PUSH produces no memory write.
